// File: rtl/proc_pkg.sv
// Shared definitions for the execute stage: opcodes, ALU control
// encodings, condition-code bit positions and the interrupt FSM state.
package proc_pkg;

   localparam int OPW = 5;

   localparam logic [OPW-1:0] OP_NOP  = 5'd0;
   localparam logic [OPW-1:0] OP_ADD  = 5'd1;
   localparam logic [OPW-1:0] OP_NOT  = 5'd2;
   localparam logic [OPW-1:0] OP_LDD  = 5'd3;
   localparam logic [OPW-1:0] OP_STD  = 5'd4;
   localparam logic [OPW-1:0] OP_SETC = 5'd5;
   localparam logic [OPW-1:0] OP_CLRC = 5'd6;
   localparam logic [OPW-1:0] OP_JZ   = 5'd7;
   localparam logic [OPW-1:0] OP_JN   = 5'd8;
   localparam logic [OPW-1:0] OP_JC   = 5'd9;
   localparam logic [OPW-1:0] OP_JMP  = 5'd10;

   localparam logic [3:0] ALU_ADD      = 4'h0;
   localparam logic [3:0] ALU_NOT      = 4'h1;
   localparam logic [3:0] ALU_PASS_LDD = 4'h2;
   localparam logic [3:0] ALU_PASS_STD = 4'h3;
   localparam logic [3:0] ALU_IDLE     = 4'hF;

   localparam int CCR_C = 2;
   localparam int CCR_N = 1;
   localparam int CCR_Z = 0;

   typedef enum logic {
      ST_RUN,
      ST_INT_HELD
   } int_state_e;

endpackage

// File: rtl/flag_update.sv
// Combinational next-CCR and branch decision for one opcode.
// Ports: op_code, ccr, alu_c/n/z in; ccr_next, take out.
module flag_update
   import proc_pkg::*;
(
   input  logic [OPW-1:0] op_code,
   input  logic [2:0]     ccr,
   input  logic           alu_c,
   input  logic           alu_n,
   input  logic           alu_z,
   output logic [2:0]     ccr_next,
   output logic           take
);

   always_comb begin
      ccr_next = ccr;
      take     = 1'b0;
      unique case (op_code)
         OP_ADD: begin
            ccr_next[CCR_C] = alu_c;
            ccr_next[CCR_N] = alu_n;
            ccr_next[CCR_Z] = alu_z;
         end
         OP_NOT, OP_LDD: begin
            ccr_next[CCR_N] = alu_n;
            ccr_next[CCR_Z] = alu_z;
         end
         OP_SETC: ccr_next[CCR_C] = 1'b1;
         OP_CLRC: ccr_next[CCR_C] = 1'b0;
         // Conditional jumps consume the flag they test.
         OP_JZ: begin
            take            = ccr[CCR_Z];
            ccr_next[CCR_Z] = 1'b0;
         end
         OP_JN: begin
            take            = ccr[CCR_N];
            ccr_next[CCR_N] = 1'b0;
         end
         OP_JC: begin
            take            = ccr[CCR_C];
            ccr_next[CCR_C] = 1'b0;
         end
         OP_JMP: take = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_flag_ctrl.sv
// Execute-stage ALU control decode, CCR ownership and interrupt save/restore.
// Ports: clk, rst, stall, flush, op_valid, op_code, alu_c/n/z, int_req, rti in;
//        alu_ctrl, ccr, branch_taken, int_held, rti_err out.
module alu_flag_ctrl
   import proc_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           stall,
   input  logic           flush,
   input  logic           op_valid,
   input  logic [OPW-1:0] op_code,
   input  logic           alu_c,
   input  logic           alu_n,
   input  logic           alu_z,
   input  logic           int_req,
   input  logic           rti,
   output logic [3:0]     alu_ctrl,
   output logic [2:0]     ccr,
   output logic           branch_taken,
   output logic           int_held,
   output logic           rti_err
);

   int_state_e state_q;
   logic [2:0] ccr_q;
   logic [2:0] saved_q;
   logic       bt_q;
   logic       rti_err_q;

   logic       live;
   logic [2:0] fu_ccr;
   logic       fu_take;
   logic [2:0] ccr_d;
   logic       bt_d;

   always_comb begin
      alu_ctrl = ALU_IDLE;
      if (op_valid) begin
         unique case (op_code)
            OP_ADD:  alu_ctrl = ALU_ADD;
            OP_NOT:  alu_ctrl = ALU_NOT;
            OP_LDD:  alu_ctrl = ALU_PASS_LDD;
            OP_STD:  alu_ctrl = ALU_PASS_STD;
            default: alu_ctrl = ALU_IDLE;
         endcase
      end
   end

   flag_update u_flag_update (
      .op_code  (op_code),
      .ccr      (ccr_q),
      .alu_c    (alu_c),
      .alu_n    (alu_n),
      .alu_z    (alu_z),
      .ccr_next (fu_ccr),
      .take     (fu_take)
   );

   assign live  = op_valid & ~flush & ~stall;
   assign ccr_d = live ? fu_ccr : ccr_q;
   assign bt_d  = live & fu_take;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RUN;
         ccr_q     <= 3'b000;
         saved_q   <= 3'b000;
         bt_q      <= 1'b0;
         rti_err_q <= 1'b0;
      end else if (!stall) begin
         bt_q      <= bt_d;
         rti_err_q <= 1'b0;
         ccr_q     <= ccr_d;
         unique case (state_q)
            ST_RUN: begin
               if (rti) rti_err_q <= 1'b1;
               // Snapshot includes this cycle's op so it is not lost.
               if (int_req) begin
                  saved_q <= ccr_d;
                  state_q <= ST_INT_HELD;
               end
            end
            ST_INT_HELD: begin
               if (rti) begin
                  ccr_q   <= saved_q;
                  state_q <= ST_RUN;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign ccr          = ccr_q;
   assign branch_taken = bt_q;
   assign rti_err      = rti_err_q;
   assign int_held     = (state_q == ST_INT_HELD);

endmodule
